// File: rtl/tb_clock_gen_multi.sv
// Multi-channel divided-clock generator: NCH channels with independent period, low time, offset and
// polarity, derived by cycle counting from CLK. Supports freeze and glitch-free stop on run fall.
module tb_clock_gen_multi #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CW         = 16,
  parameter bit          INITIALIZE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        tb_status,
  input  logic [NCH*CW-1:0] period_bits,
  input  logic [NCH*CW-1:0] low_bits,
  input  logic [NCH*CW-1:0] offset_bits,
  input  logic [NCH-1:0]    invert,
  output logic [NCH-1:0]    CLK_OUT,
  output logic [NCH-1:0]    active,
  output logic [NCH-1:0]    err
);

  typedef enum logic [1:0] {StIdle, StOffset, StLow, StHigh} state_e;

  logic w_run, w_frz;
  logic r_run_d, r_start;

  assign w_run = tb_status[0];
  assign w_frz = tb_status[1];

  // Start is registered so that state, outputs and err all change together one edge later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_run_d <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_run_d <= w_run;
      r_start <= w_run & ~r_run_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt, r_low, w_low, r_high, w_high;
    logic [CW-1:0]   w_per_in, w_low_in, w_off_in;
    logic            r_inv, w_inv, r_err, w_err, r_clk, r_act, w_raw;

    assign w_per_in = period_bits[i*CW +: CW];
    assign w_low_in = low_bits[i*CW +: CW];
    assign w_off_in = offset_bits[i*CW +: CW];

    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_low   = r_low;
      w_high  = r_high;
      w_inv   = r_inv;
      w_err   = r_err;
      if (r_start && (r_state == StIdle)) begin
        w_inv = invert[i];
        if ((w_per_in == '0) || (w_low_in == '0) || (w_low_in >= w_per_in)) begin
          w_err = 1'b1;
        end else begin
          w_err  = 1'b0;
          w_low  = w_low_in;
          w_high = w_per_in - w_low_in;
          if (w_off_in != '0) begin
            w_state = StOffset;
            w_cnt   = w_off_in;
          end else begin
            w_state = StLow;
            w_cnt   = w_low_in;
          end
        end
      end else if (!w_frz) begin
        // r_cnt holds the cycles left in the current phase, including this one.
        unique case (r_state)
          StIdle: ;
          StOffset: begin
            if (!w_run) begin
              w_state = StIdle;
            end else if (r_cnt == CW'(1)) begin
              w_state = StLow;
              w_cnt   = r_low;
            end else begin
              w_cnt = r_cnt - CW'(1);
            end
          end
          StLow: begin
            if (r_cnt == CW'(1)) begin
              w_state = StHigh;
              w_cnt   = r_high;
            end else begin
              w_cnt = r_cnt - CW'(1);
            end
          end
          StHigh: begin
            if (r_cnt == CW'(1)) begin
              w_state = w_run ? StLow : StIdle;
              w_cnt   = r_low;
            end else begin
              w_cnt = r_cnt - CW'(1);
            end
          end
          default: w_state = StIdle;
        endcase
      end
    end

    always_comb begin
      unique case (w_state)
        StHigh:   w_raw = 1'b1;
        StOffset: w_raw = INITIALIZE;
        default:  w_raw = 1'b0;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_low   <= '0;
        r_high  <= '0;
        r_inv   <= 1'b0;
        r_err   <= 1'b0;
        r_clk   <= 1'b0;
        r_act   <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_low   <= w_low;
        r_high  <= w_high;
        r_inv   <= w_inv;
        r_err   <= w_err;
        r_clk   <= w_raw ^ w_inv;
        r_act   <= (w_state != StIdle);
      end
    end

    assign CLK_OUT[i] = r_clk;
    assign active[i]  = r_act;
    assign err[i]     = r_err;
  end

endmodule

// File: tb/tb_tb_clock_gen_multi.sv
// Directed bench for tb_clock_gen_multi: waveform shape, offset/polarity, config rejection,
// glitch-free stop, freeze stretch and mid-run reset.
module tb_tb_clock_gen_multi;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        tb_status;
  logic [NCH*CW-1:0] period_bits, low_bits, offset_bits;
  logic [NCH-1:0]    invert, CLK_OUT, active, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] exp_a0, exp_a1;
  logic [7:0]  exp_b0, exp_b1, exp_r0;
  logic [23:0] exp_f0;

  tb_clock_gen_multi #(.NCH(NCH), .CW(CW), .INITIALIZE(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tb_status  (tb_status),
    .period_bits(period_bits),
    .low_bits   (low_bits),
    .offset_bits(offset_bits),
    .invert     (invert),
    .CLK_OUT    (CLK_OUT),
    .active     (active),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int per, input int low, input int off, input logic inv);
    period_bits[ch*CW +: CW] = CW'(per);
    low_bits[ch*CW +: CW]    = CW'(low);
    offset_bits[ch*CW +: CW] = CW'(off);
    invert[ch]               = inv;
  endtask

  initial begin
    RST = 1'b1;
    tb_status = 2'b00;
    period_bits = '0;
    low_bits = '0;
    offset_bits = '0;
    invert = '0;
    tick();
    tick();
    check("reset_clk", 32'(CLK_OUT), 32'h0);
    check("reset_active", 32'(active), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    RST = 1'b0;
    tick();

    // ch0 4/1/0, ch1 10/3/5 inverted, ch2 and ch3 invalid
    cfg(0, 4, 1, 0, 1'b0);
    cfg(1, 10, 3, 5, 1'b1);
    cfg(2, 6, 6, 0, 1'b0);
    cfg(3, 0, 2, 0, 1'b1);
    tb_status = 2'b01;
    tick();
    check("err_before_k1", 32'(err), 32'h0);
    check("active_before_k1", 32'(active), 32'h0);
    tick();
    check("start_active", 32'(active), 32'h3);
    check("start_err", 32'(err), 32'hc);
    check("invalid_levels", 32'(CLK_OUT[3:2]), 32'h2);
    exp_a0 = 20'b01110111011101110111;
    exp_a1 = 20'b00000111000000011100;
    for (int j = 0; j < 20; j++) begin
      check($sformatf("ch0_p4_j%0d", j), 32'(CLK_OUT[0]), 32'(exp_a0[19-j]));
      check($sformatf("ch1_off_j%0d", j), 32'(CLK_OUT[1]), 32'(exp_a1[19-j]));
      check($sformatf("ch23_idle_j%0d", j), 32'(active[3:2]), 32'h0);
      tick();
    end
    tb_status = 2'b00;
    for (int j = 0; j < 30; j++) tick();
    check("all_stopped", 32'(active), 32'h0);
    check("err_persists", 32'(err), 32'hc);

    // Valid restart; then drop run during ch0 LOW
    cfg(0, 8, 4, 0, 1'b0);
    cfg(2, 6, 2, 0, 1'b0);
    cfg(3, 4, 2, 0, 1'b1);
    tb_status = 2'b01;
    tick();
    tick();
    check("restart_err_clear", 32'(err), 32'h0);
    check("restart_active", 32'(active), 32'hf);
    check("stop_ch0_j0", 32'(CLK_OUT[0]), 32'h0);
    tick();
    check("stop_ch0_j1", 32'(CLK_OUT[0]), 32'h0);
    tb_status = 2'b00;
    exp_b0 = 8'b00111100;
    exp_b1 = 8'b11111100;
    for (int j = 2; j < 10; j++) begin
      tick();
      check($sformatf("stop_ch0_j%0d", j), 32'(CLK_OUT[0]), 32'(exp_b0[9-j]));
      check($sformatf("stop_act0_j%0d", j), 32'(active[0]), 32'(exp_b1[9-j]));
      check($sformatf("stop_act1_j%0d", j), 32'(active[1]), 32'h0);
    end
    check("stopped_active", 32'(active), 32'h0);
    check("stopped_levels", 32'(CLK_OUT), 32'ha);

    // Freeze 7 cycles inside ch0 HIGH
    tick();
    tick();
    tb_status = 2'b01;
    tick();
    tick();
    exp_f0 = 24'b000011111111111000011110;
    for (int j = 0; j < 24; j++) begin
      check($sformatf("frz_ch0_j%0d", j), 32'(CLK_OUT[0]), 32'(exp_f0[23-j]));
      if (j == 5) tb_status = 2'b11;
      if (j == 12) tb_status = 2'b01;
      tick();
    end

    // Reset while everything runs, then clean restart
    check("pre_rst_active", 32'(active), 32'hf);
    RST = 1'b1;
    tb_status = 2'b00;
    tick();
    check("rst_clk", 32'(CLK_OUT), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    RST = 1'b0;
    tick();
    check("post_rst_clk", 32'(CLK_OUT), 32'h0);
    tb_status = 2'b01;
    tick();
    tick();
    check("rerun_active", 32'(active), 32'hf);
    check("rerun_err", 32'(err), 32'h0);
    check("rerun_ch1_offset", 32'(CLK_OUT[1]), 32'h0);
    exp_r0 = 8'b00001111;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("rerun_ch0_j%0d", j), 32'(CLK_OUT[0]), 32'(exp_r0[7-j]));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
